// File: rtl/me_job_sched.sv
// Round-robin scheduler sharing one non-pipelined modular-exponentiation core among N_REQ requesters.
// Latency: grant -> core enable pulse 1 cycle; core_done -> rsp_valid 1 cycle; one job in flight.
// Backpressure: a requester holds req_valid until its one-cycle req_ready strobe; no new grant until RESP ends.
module me_job_sched #(
  parameter int          N_REQ   = 4,
  parameter int          SEL_W   = 2,
  parameter int          TAG_W   = 4,
  parameter int          TO_W    = 20,
  parameter int unsigned TIMEOUT = 20'hFFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [TAG_W*N_REQ-1:0] req_tag,
  output logic [N_REQ-1:0]       req_ready,
  output logic [SEL_W-1:0]       sel,
  output logic                   en_pre_me,
  output logic                   en_me,
  output logic                   en_one_mm,
  output logic [TAG_W-1:0]       num,
  input  logic                   core_done,
  input  logic [TAG_W-1:0]       core_num_out,
  output logic                   rsp_valid,
  output logic [SEL_W-1:0]       rsp_req,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [1:0]             rsp_err,
  output logic                   busy,
  output logic                   stale_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_PRE_ME = 2'b00;
  localparam logic [1:0] OP_ME     = 2'b01;
  localparam logic [1:0] OP_ONE_MM = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TAG     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Last WAIT count before giving up on the core.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  rr_q, rr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [1:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [1:0]        err_q, err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              stale_q, stale_d;

  logic              gnt_found;
  logic [SEL_W-1:0]  gnt_idx;
  logic [SEL_W-1:0]  cand;
  logic [1:0]        gnt_op;
  logic [TAG_W-1:0]  gnt_tag;

  // Cyclic search for the first valid requester at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    cand      = rr_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = rr_q + SEL_W'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_op  = req_op[2*int'(gnt_idx) +: 2];
    gnt_tag = req_tag[TAG_W*int'(gnt_idx) +: TAG_W];
  end

  // Next-state and strobe outputs; the core enable is a pure decode of ISSUE so it is exactly one cycle.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    op_d      = op_q;
    tag_d     = tag_q;
    err_d     = err_q;
    cnt_d     = '0;
    req_ready = '0;
    en_pre_me = 1'b0;
    en_me     = 1'b0;
    en_one_mm = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          sel_d = gnt_idx;
          op_d  = gnt_op;
          tag_d = gnt_tag;
          rr_d  = gnt_idx + SEL_W'(1);
          if (gnt_op == OP_ILLEGAL) begin
            // Illegal op short-circuits straight to the response; the core never sees it.
            state_d = S_RESP;
            err_d   = ERR_ILLEGAL;
          end else begin
            state_d = S_ISSUE;
            err_d   = ERR_OK;
          end
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_PRE_ME: en_pre_me = 1'b1;
          OP_ME:     en_me     = 1'b1;
          OP_ONE_MM: en_one_mm = 1'b1;
          default:   ;
        endcase
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        // A done arriving on the timeout cycle still counts as a completion.
        if (core_done) begin
          state_d = S_RESP;
          err_d   = (core_num_out == tag_q) ? ERR_OK : ERR_TAG;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_RESP;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A core_done outside WAIT cannot belong to the job in flight; remember it until reset.
  always_comb begin
    stale_d = stale_q | (core_done && (state_q != S_WAIT));
  end

  // State and job registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  // Response fields are zero except during the RESP strobe.
  always_comb begin
    rsp_valid  = (state_q == S_RESP);
    rsp_req    = rsp_valid ? sel_q : '0;
    rsp_tag    = rsp_valid ? tag_q : '0;
    rsp_err    = rsp_valid ? err_q : '0;
    busy       = (state_q != S_IDLE);
    sel        = sel_q;
    num        = tag_q;
    stale_done = stale_q;
  end

endmodule

// File: tb/tb_me_job_sched.sv
// Directed bench for me_job_sched: one default instance and one with a short timeout.
// Inputs are driven 2 time units after each rising edge and outputs sampled 1 unit later.
// Each scenario task does its own inline comparisons against hand-computed values.
module tb_me_job_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op = '0;
  logic [15:0] req_tag = '0;
  logic        core_done = 1'b0;
  logic [3:0]  core_num_out = '0;

  logic [3:0] req_ready, t_req_ready;
  logic [1:0] sel, t_sel, rsp_req, t_rsp_req, rsp_err, t_rsp_err;
  logic       en_pre_me, en_me, en_one_mm, t_en_pre_me, t_en_me, t_en_one_mm;
  logic [3:0] num, t_num, rsp_tag, t_rsp_tag;
  logic       rsp_valid, t_rsp_valid, busy, t_busy, stale_done, t_stale_done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  me_job_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_tag(req_tag),
    .req_ready(req_ready), .sel(sel), .en_pre_me(en_pre_me), .en_me(en_me), .en_one_mm(en_one_mm),
    .num(num), .core_done(core_done), .core_num_out(core_num_out), .rsp_valid(rsp_valid),
    .rsp_req(rsp_req), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy), .stale_done(stale_done)
  );

  me_job_sched #(.TIMEOUT(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_tag(req_tag),
    .req_ready(t_req_ready), .sel(t_sel), .en_pre_me(t_en_pre_me), .en_me(t_en_me), .en_one_mm(t_en_one_mm),
    .num(t_num), .core_done(core_done), .core_num_out(core_num_out), .rsp_valid(t_rsp_valid),
    .rsp_req(t_rsp_req), .rsp_tag(t_rsp_tag), .rsp_err(t_rsp_err), .busy(t_busy), .stale_done(t_stale_done)
  );

  wire [2:0] ens   = {en_pre_me, en_me, en_one_mm};
  wire [2:0] t_ens = {t_en_pre_me, t_en_me, t_en_one_mm};

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_tag = '0; core_done = 1'b0; core_num_out = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    tests_run++; if (req_ready !== 4'b0) begin tests_failed++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
    tests_run++; if (ens !== 3'b0) begin tests_failed++; $display("FAIL reset_en: got %0b want 000", ens); end
    tests_run++; if ({sel, num} !== 6'b0) begin tests_failed++; $display("FAIL reset_sel_num: got %0h want 0", {sel, num}); end
    tests_run++; if (stale_done !== 1'b0) begin tests_failed++; $display("FAIL reset_stale: got %0b want 0", stale_done); end
  endtask

  // Req0 op=10 tag=3, core answers after 800 cycles with the right tag.
  task automatic test_single_job();
    int extra_en = 0;
    int early_rsp = 0;
    do_reset();
    req_valid = 4'b0001; req_op = 8'b0000_0010; req_tag = 16'h0003;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_ready: got %0b want 0001", req_ready); end
    next(); req_valid = '0; #1;
    tests_run++; if (ens !== 3'b001) begin tests_failed++; $display("FAIL single_en: got %0b want 001", ens); end
    tests_run++; if (num !== 4'd3 || sel !== 2'd0) begin tests_failed++; $display("FAIL single_num_sel: got num=%0d sel=%0d want 3,0", num, sel); end
    for (int i = 0; i < 799; i++) begin
      next(); #1;
      if (ens !== 3'b0) extra_en++;
      if (rsp_valid !== 1'b0) early_rsp++;
    end
    tests_run++; if (extra_en !== 0) begin tests_failed++; $display("FAIL single_extra_en: got %0d want 0", extra_en); end
    tests_run++; if (early_rsp !== 0) begin tests_failed++; $display("FAIL single_early_rsp: got %0d want 0", early_rsp); end
    next(); core_done = 1'b1; core_num_out = 4'd3; #1;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_rsp_same_cycle: got %0b want 0", rsp_valid); end
    next(); core_done = 1'b0; #1;
    tests_run++; if ({rsp_valid, rsp_req, rsp_tag, rsp_err} !== {1'b1, 2'd0, 4'd3, 2'b00}) begin
      tests_failed++; $display("FAIL single_rsp: got v=%0b req=%0d tag=%0d err=%0b want 1,0,3,00", rsp_valid, rsp_req, rsp_tag, rsp_err);
    end
    tests_run++; if (req_ready !== 4'b0 || ens !== 3'b0) begin tests_failed++; $display("FAIL single_rsp_exclusive: got ready=%0b en=%0b want 0,0", req_ready, ens); end
    next(); #1;
    tests_run++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got busy=%0b rsp=%0b want 0,0", busy, rsp_valid); end
  endtask

  // All four requesters valid continuously; a small core model answers 3 cycles after each enable.
  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int grants = 0;
    int en_total = 0;
    int multi_en = 0;
    int overlap = 0;
    int bad_rsp = 0;
    int bad_issue = 0;
    int last_g = 0;
    int dly = 0;
    int g;
    logic [3:0] pend = '0;
    do_reset();
    req_valid = 4'hF;
    req_op = {2'b00, 2'b10, 2'b01, 2'b00};
    req_tag = {4'hD, 4'hC, 4'hB, 4'hA};
    for (int cyc = 0; cyc < 200 && grants < 5; cyc++) begin
      core_done = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin core_done = 1'b1; core_num_out = pend; end
      end
      #1;
      if (req_ready !== 4'b0) begin
        g = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        tests_run++;
        if ($countones(req_ready) != 1 || g != exp_seq[grants]) begin
          tests_failed++; $display("FAIL rr_grant%0d: got ready=%0b want index %0d", grants, req_ready, exp_seq[grants]);
        end
        last_g = g;
        grants++;
      end
      if (ens !== 3'b0) begin
        en_total++;
        if ($countones(ens) != 1) multi_en++;
        if (int'(sel) != last_g || num !== 4'hA + 4'(last_g)) bad_issue++;
        pend = num;
        dly = 3;
      end
      if (int'(req_ready != 4'b0) + int'(ens != 3'b0) + int'(rsp_valid) > 1) overlap++;
      if (rsp_valid && rsp_err !== 2'b00) bad_rsp++;
      next();
    end
    req_valid = '0; core_done = 1'b0;
    tests_run++; if (grants !== 5) begin tests_failed++; $display("FAIL rr_grant_count: got %0d want 5", grants); end
    tests_run++; if (en_total !== 4) begin tests_failed++; $display("FAIL rr_en_count: got %0d want 4", en_total); end
    tests_run++; if (multi_en !== 0) begin tests_failed++; $display("FAIL rr_multi_en: got %0d want 0", multi_en); end
    tests_run++; if (bad_issue !== 0) begin tests_failed++; $display("FAIL rr_issue_sel_num: got %0d bad want 0", bad_issue); end
    tests_run++; if (overlap !== 0) begin tests_failed++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
    tests_run++; if (bad_rsp !== 0) begin tests_failed++; $display("FAIL rr_rsp_err: got %0d bad want 0", bad_rsp); end
  endtask

  // Req2 op=11 tag=5: no core enable, error response straight after the grant.
  task automatic test_illegal_op();
    do_reset();
    req_valid = 4'b0100; req_op = 8'b0011_0000; req_tag = 16'h0500;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL illegal_ready: got %0b want 0100", req_ready); end
    next(); req_valid = '0; #1;
    tests_run++; if (ens !== 3'b0) begin tests_failed++; $display("FAIL illegal_en: got %0b want 000", ens); end
    tests_run++; if ({rsp_valid, rsp_req, rsp_tag, rsp_err} !== {1'b1, 2'd2, 4'd5, 2'b01}) begin
      tests_failed++; $display("FAIL illegal_rsp: got v=%0b req=%0d tag=%0d err=%0b want 1,2,5,01", rsp_valid, rsp_req, rsp_tag, rsp_err);
    end
    next(); #1;
    tests_run++; if (busy !== 1'b0 || ens !== 3'b0) begin tests_failed++; $display("FAIL illegal_after: got busy=%0b en=%0b want 0,000", busy, ens); end
  endtask

  // Req1 op=01 tag=7, core returns num_out=6.
  task automatic test_tag_mismatch();
    do_reset();
    req_valid = 4'b0010; req_op = 8'b0000_0100; req_tag = 16'h0070;
    #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL mism_ready: got %0b want 0010", req_ready); end
    next(); req_valid = '0; #1;
    tests_run++; if (ens !== 3'b010 || num !== 4'd7 || sel !== 2'd1) begin
      tests_failed++; $display("FAIL mism_issue: got en=%0b num=%0d sel=%0d want 010,7,1", ens, num, sel);
    end
    next(); core_done = 1'b1; core_num_out = 4'd6; #1;
    next(); core_done = 1'b0; #1;
    tests_run++; if ({rsp_valid, rsp_req, rsp_tag, rsp_err} !== {1'b1, 2'd1, 4'd7, 2'b10}) begin
      tests_failed++; $display("FAIL mism_rsp: got v=%0b req=%0d tag=%0d err=%0b want 1,1,7,10", rsp_valid, rsp_req, rsp_tag, rsp_err);
    end
  endtask

  // TIMEOUT=16 instance: silent core times out after 16 WAIT cycles; next job completes on the last WAIT cycle.
  task automatic test_timeout();
    int early = 0;
    do_reset();
    req_valid = 4'b0001; req_op = 8'b0000_0000; req_tag = 16'h0009;
    #1;
    tests_run++; if (t_req_ready !== 4'b0001) begin tests_failed++; $display("FAIL to_ready: got %0b want 0001", t_req_ready); end
    next(); req_valid = '0; #1;
    tests_run++; if (t_ens !== 3'b100) begin tests_failed++; $display("FAIL to_en: got %0b want 100", t_ens); end
    for (int i = 0; i < 16; i++) begin
      next(); #1;
      if (t_rsp_valid !== 1'b0 || t_busy !== 1'b1) early++;
    end
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL to_early: got %0d bad cycles want 0", early); end
    next(); #1;
    tests_run++; if ({t_rsp_valid, t_rsp_req, t_rsp_tag, t_rsp_err} !== {1'b1, 2'd0, 4'd9, 2'b11}) begin
      tests_failed++; $display("FAIL to_rsp: got v=%0b req=%0d tag=%0d err=%0b want 1,0,9,11", t_rsp_valid, t_rsp_req, t_rsp_tag, t_rsp_err);
    end
    next(); #1;
    tests_run++; if (t_busy !== 1'b0) begin tests_failed++; $display("FAIL to_idle: got busy=%0b want 0", t_busy); end
    req_valid = 4'b1000; req_op = 8'b0100_0000; req_tag = 16'h2000;
    #1;
    tests_run++; if (t_req_ready !== 4'b1000) begin tests_failed++; $display("FAIL to2_ready: got %0b want 1000", t_req_ready); end
    next(); req_valid = '0; #1;
    tests_run++; if (t_ens !== 3'b010 || t_num !== 4'd2) begin tests_failed++; $display("FAIL to2_issue: got en=%0b num=%0d want 010,2", t_ens, t_num); end
    early = 0;
    for (int i = 0; i < 15; i++) begin
      next(); #1;
      if (t_rsp_valid !== 1'b0) early++;
    end
    next(); core_done = 1'b1; core_num_out = 4'd2; #1;
    if (t_rsp_valid !== 1'b0) early++;
    next(); core_done = 1'b0; #1;
    tests_run++; if (early !== 0) begin tests_failed++; $display("FAIL to2_early: got %0d want 0", early); end
    tests_run++; if ({t_rsp_valid, t_rsp_req, t_rsp_tag, t_rsp_err} !== {1'b1, 2'd3, 4'd2, 2'b00}) begin
      tests_failed++; $display("FAIL to2_done_wins: got v=%0b req=%0d tag=%0d err=%0b want 1,3,2,00", t_rsp_valid, t_rsp_req, t_rsp_tag, t_rsp_err);
    end
  endtask

  // Reset asserted during WAIT aborts the job; a later done while idle sets the sticky flag.
  task automatic test_reset_mid_job();
    int rsp_seen = 0;
    do_reset();
    req_valid = 4'b0001; req_op = 8'b0000_0001; req_tag = 16'h0004;
    next(); req_valid = '0;
    next(); next(); #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_busy_before: got %0b want 1", busy); end
    rst_n = 1'b0; #1;
    tests_run++; if ({busy, rsp_valid, ens, sel, num, stale_done} !== 12'b0) begin
      tests_failed++; $display("FAIL rst_async_outputs: got busy=%0b rsp=%0b en=%0b sel=%0d num=%0d stale=%0b want all 0", busy, rsp_valid, ens, sel, num, stale_done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next(); #1;
      if (rsp_valid !== 1'b0) rsp_seen++;
    end
    tests_run++; if (rsp_seen !== 0) begin tests_failed++; $display("FAIL rst_no_rsp: got %0d want 0", rsp_seen); end
    core_done = 1'b1; core_num_out = 4'd4; #1;
    tests_run++; if (stale_done !== 1'b0) begin tests_failed++; $display("FAIL stale_early: got %0b want 0", stale_done); end
    next(); core_done = 1'b0; #1;
    tests_run++; if ({stale_done, busy, rsp_valid} !== 3'b100) begin
      tests_failed++; $display("FAIL stale_set: got stale=%0b busy=%0b rsp=%0b want 1,0,0", stale_done, busy, rsp_valid);
    end
    next(); next(); #1;
    tests_run++; if (stale_done !== 1'b1) begin tests_failed++; $display("FAIL stale_sticky: got %0b want 1", stale_done); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_illegal_op();
    test_tag_mismatch();
    test_timeout();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
